fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, pipelined floating-point multiplier with valid/ready handshakes on input and output.
- Next generation of the combinational 16-bit multiplier: exponent and mantissa widths are configurable, and the mantissa can be approximated by truncation.
- Defaults are bfloat16.
- Sits between an operand producer and a result consumer, both of which may stall.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MANT_WIDTH, 7, stored mantissa field width, excluding the hidden bit.
- TRUNC_MANT_BITS, 0, number of operand-mantissa LSBs forced to zero before multiplication (approximate mode); legal range 0..MANT_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- a_operand  input  1+EXP_WIDTH+MANT_WIDTH  operand A, {sign, exp, mant}.
- b_operand  input  1+EXP_WIDTH+MANT_WIDTH  operand B, same format as A.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  1+EXP_WIDTH+MANT_WIDTH  product.
- overflow  output  1  product magnitude exceeds the format's range; qualified by out_valid.
- underflow  output  1  nonzero product flushed to zero; qualified by out_valid.
- exception  output  1  an operand is Inf or NaN; qualified by out_valid.

Behaviour:
- Three-stage pipeline, each stage with its own valid bit:
  - S1: unpack operands, classify, add exponents.
  - S2: multiply mantissas, (MANT_WIDTH+1)x(MANT_WIDTH+1) bits.
  - S3: normalise, round, pack, set flags.
- Stage k advances when stage k+1 is empty or advancing. S3 advances when out_ready=1 or out_valid=0.
- in_ready = !S1.valid or S1 advancing. A transfer occurs when in_valid and in_ready are both 1.
- Latency: 3 cycles from accept to out_valid while out_ready is held high. Throughput: 1 result per cycle.
- Stall: while out_valid=1 and out_ready=0, result and flags hold stable. At most 3 operand pairs are in flight; none are dropped or duplicated.
- Simultaneous accept and drain with the pipeline full: legal; throughput is maintained.
- Reset (asynchronous, also when asserted mid-operation): all valid bits are cleared; out_valid=0, result=0, all flags=0; in-flight data is discarded. in_ready=1 from the first cycle after rst_n is released.
- Classification:
  - exp=0 means zero; subnormals are flushed to zero on input.
  - exp all-ones with mant=0 is Inf; with mant!=0 it is NaN.
- Sign of the result = sign_a XOR sign_b in all cases.
- Special cases:
  - Either operand NaN, or Inf times zero: result = canonical quiet NaN, {0, all-ones exp, 1 followed by zeros}; exception=1.
  - Otherwise, either operand Inf: result = signed Inf; exception=1.
  - Otherwise, either operand zero: result = signed zero; no flags.
- Exponent: e = ea + eb - bias, computed at width EXP_WIDTH+2 as a signed value. If the mantissa product MSB is set, shift right 1 and e = e+1.
- Approximate mode: the TRUNC_MANT_BITS LSBs of each stored mantissa are zeroed in S1. Special-case classification uses the untruncated mantissa.
- Default rounding: truncation toward zero; the retained mantissa is the top MANT_WIDTH bits after the hidden bit.
- Range checks:
  - e >= 2^EXP_WIDTH-1 after normalisation and rounding: result = signed Inf; overflow=1.
  - e <= 0: result = signed zero; underflow=1.
- Flags are mutually exclusive per result.

Optional Feature:
- Macro FPMULT_RNE_ROUND_EN.
- Defined: round-to-nearest-even in S3 using the guard bit and a sticky OR of the lower product bits. A mantissa carry-out renormalises and increments e; the overflow check runs after rounding.
- Undefined: truncation only; no guard/sticky logic is synthesised.

Test Plan:
- Defaults: 0x3FC0 x 0x4000 -> 0x4040 three cycles after accept, all flags 0.
- 0x3FC3 x 0x3FC3 -> 0x4014 without FPMULT_RNE_ROUND_EN; -> 0x4015 with it.
- Range limits: 0x7F00 x 0x4000 -> 0x7F80, overflow=1. 0x0080 x 0x3F00 -> 0x0000, underflow=1.
- Special values: 0x7F80 x 0x0000 -> 0x7FC0, exception=1. 0xFF80 x 0x4000 -> 0xFF80, exception=1.
- Backpressure: stream 10 pairs, hold out_ready=0 for cycles 4-8. in_ready drops once 3 pairs are in flight; all 10 results come out in order, bit-exact, with result stable throughout the stall.
- TRUNC_MANT_BITS=4: 0x3FC3 x 0x3FC3 -> 0x4010. Asserting rst_n=0 with 2 pairs in flight -> out_valid=0 immediately; neither result ever appears.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (defaults: bfloat16) with valid/ready on both sides.
// Define FPMULT_RNE_ROUND_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mult_pipe #(
  parameter int EXP_WIDTH       = 8,
  parameter int MANT_WIDTH      = 7,
  parameter int TRUNC_MANT_BITS = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   a_operand,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   b_operand,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   result,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            exception
);

  localparam int W  = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int EW = EXP_WIDTH + 2;
  localparam int MW = MANT_WIDTH + 1;
  localparam int PW = 2 * MW;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_WIDTH) - 1);
  localparam logic [MANT_WIDTH-1:0] TRUNC_MASK = ~MANT_WIDTH'((1 << TRUNC_MANT_BITS) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} | (W'(1) << (MANT_WIDTH - 1));

  typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

`ifdef FPMULT_RNE_ROUND_EN
  function automatic logic [MANT_WIDTH:0] round_mant(input logic [MANT_WIDTH-1:0] m,
                                                     input logic g, input logic s);
    return {1'b0, m} + (MANT_WIDTH + 1)'(g & (s | m[0]));
  endfunction
`else
  function automatic logic [MANT_WIDTH:0] round_mant(input logic [MANT_WIDTH-1:0] m);
    return {1'b0, m};
  endfunction
`endif

  // Returns {overflow, underflow, packed result}.
  function automatic logic [W+1:0] saturate(input logic s, input logic signed [EW-1:0] e,
                                            input logic [MANT_WIDTH-1:0] m);
    if (e >= EMAX)   return {2'b10, s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    else if (e <= 0) return {2'b01, s, {(W-1){1'b0}}};
    else             return {2'b00, s, e[EXP_WIDTH-1:0], m};
  endfunction

  logic sign_a, sign_b;
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  logic [MANT_WIDTH-1:0] man_a, man_b;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  kind_t kind_in;

  assign {sign_a, exp_a, man_a} = a_operand;
  assign {sign_b, exp_b, man_b} = b_operand;
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (&exp_a) && (man_a == '0);
  assign inf_b  = (&exp_b) && (man_b == '0);
  assign nan_a  = (&exp_a) && (man_a != '0);
  assign nan_b  = (&exp_b) && (man_b != '0);

  always_comb begin
    kind_in = K_NORM;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) kind_in = K_NAN;
    else if (inf_a || inf_b)                                      kind_in = K_INF;
    else if (zero_a || zero_b)                                    kind_in = K_ZERO;
  end

  logic vld_p0, vld_p1, vld_p2;
  logic adv_p0, adv_p1, adv_p2;

  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign adv_p0    = !vld_p0 || adv_p1;
  assign in_ready  = adv_p0;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // S1: unpack, classify, biased exponent sum
  logic                 sign_p0;
  kind_t                kind_p0;
  logic signed [EW-1:0] exp_p0;
  logic [MW-1:0]        ma_p0, mb_p0;

  always_ff @(posedge clk) begin
    if (in_valid && adv_p0) begin
      sign_p0 <= sign_a ^ sign_b;
      kind_p0 <= kind_in;
      exp_p0  <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
      ma_p0   <= {1'b1, man_a & TRUNC_MASK};
      mb_p0   <= {1'b1, man_b & TRUNC_MASK};
    end
  end

  // S2: mantissa product
  logic                 sign_p1;
  kind_t                kind_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;

  always_ff @(posedge clk) begin
    if (vld_p0 && adv_p1) begin
      sign_p1 <= sign_p0;
      kind_p1 <= kind_p0;
      exp_p1  <= exp_p0;
      prod_p1 <= PW'(ma_p0) * PW'(mb_p0);
    end
  end

  // S3: normalise, round, range-check, pack
  logic [PW-1:0]         norm;
  logic signed [EW-1:0]  exp_n, exp_r;
  logic [MANT_WIDTH-1:0] mant_n;
  logic [MANT_WIDTH:0]   mant_r;
  logic [W+1:0]          sat;
  logic [W-1:0]          res_n;
  logic                  ov_n, un_n, ex_n;

  always_comb begin
    norm   = prod_p1[PW-1] ? prod_p1 : (prod_p1 << 1);
    exp_n  = exp_p1 + $signed(EW'(prod_p1[PW-1]));
    mant_n = MANT_WIDTH'(norm >> (MANT_WIDTH + 1));
`ifdef FPMULT_RNE_ROUND_EN
    mant_r = round_mant(mant_n, norm[MANT_WIDTH], |norm[MANT_WIDTH-1:0]);
`else
    mant_r = round_mant(mant_n);
`endif
    exp_r  = exp_n + $signed(EW'(mant_r[MANT_WIDTH]));
    sat    = saturate(sign_p1, exp_r, mant_r[MANT_WIDTH-1:0]);
    res_n  = sat[W-1:0];
    ov_n   = sat[W+1];
    un_n   = sat[W];
    ex_n   = 1'b0;
    case (kind_p1)
      K_NAN:   begin res_n = QNAN; ov_n = 1'b0; un_n = 1'b0; ex_n = 1'b1; end
      K_INF:   begin
        res_n = {sign_p1, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        ov_n = 1'b0; un_n = 1'b0; ex_n = 1'b1;
      end
      K_ZERO:  begin res_n = {sign_p1, {(W-1){1'b0}}}; ov_n = 1'b0; un_n = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (vld_p1 && adv_p2) begin
      result    <= res_n;
      overflow  <= ov_n;
      underflow <= un_n;
      exception <= ex_n;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed bfloat16 vectors, backpressure, async reset,
// randomized streaming against an arithmetic reference model, plus a TRUNC_MANT_BITS=4 instance.
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, overflow, underflow, exception;
  logic [15:0] a_operand = '0, b_operand = '0, result;

  logic        in_valid_t = 1'b0;
  logic        in_ready_t, out_valid_t, ov_t, un_t, ex_t;
  logic [15:0] a_t = '0, b_t = '0, result_t;

  fp_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .underflow(underflow), .exception(exception)
  );

  fp_mult_pipe #(.TRUNC_MANT_BITS(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t), .in_ready(in_ready_t),
    .a_operand(a_t), .b_operand(b_t), .out_valid(out_valid_t),
    .out_ready(1'b1), .result(result_t), .overflow(ov_t),
    .underflow(un_t), .exception(ex_t)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [18:0] sb_q[$];
  int n_out = 0;
  int max_infl = 0;
  logic saw_low = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: value-level bfloat16 product, returns {overflow, underflow, exception, result}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input int trunc);
    int ea, eb, ma, mb, p, e, q, dv;
    logic s, an, bn, ai, bi, az, bz;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    an = (ea == 255) && (a[6:0] != 0);
    bn = (eb == 255) && (b[6:0] != 0);
    ai = (ea == 255) && (a[6:0] == 0);
    bi = (eb == 255) && (b[6:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b001, 16'h7FC0};
    if (ai || bi) return {3'b001, s, 8'hFF, 7'h00};
    if (az || bz) return {3'b000, s, 15'h0000};
    ma = (128 + int'(a[6:0])) & ~((1 << trunc) - 1);
    mb = (128 + int'(b[6:0])) & ~((1 << trunc) - 1);
    p  = ma * mb;
    e  = ea + eb - 127;
    dv = 128;
    if (p >= 32768) begin
      dv = 256;
      e  = e + 1;
    end
    q = p / dv;
`ifdef FPMULT_RNE_ROUND_EN
    begin
      int r;
      r = p % dv;
      if ((2 * r > dv) || ((2 * r == dv) && (q % 2 == 1))) q = q + 1;
      if (q == 256) begin
        q = 128;
        e = e + 1;
      end
    end
`endif
    if (e >= 255) return {3'b100, s, 8'hFF, 7'h00};
    if (e <= 0)   return {3'b010, s, 15'h0000};
    return {3'b000, s, 8'(e), 7'(q)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [7:0] e;
    logic [6:0] m;
    int k;
    k = $urandom_range(0, 9);
    m = 7'($urandom);
    case (k)
      0: e = 8'h00;
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 7'h00; end
      2: e = 8'($urandom_range(245, 254));
      3: e = 8'($urandom_range(1, 8));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'(result), 32'(prev_res));
      if (out_valid) begin
        chk("flags_exclusive", 32'($onehot0({overflow, underflow, exception})), 32'd1);
        if (sb_q.size() == 0) begin
          chk("out_with_empty_sb", 32'(sb_q.size()), 32'd1);
        end else begin
          chk("result", 32'(result), 32'(sb_q[0][15:0]));
          chk("flags", 32'({overflow, underflow, exception}), 32'(sb_q[0][18:16]));
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(a_operand, b_operand, 0));
      if (!in_ready) saw_low = 1'b1;
      if (sb_q.size() > max_infl) max_infl = sb_q.size();
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end
  end

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                         input logic [2:0] ef, input string nm);
    int cyc, lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd3);
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_flags"}, 32'({overflow, underflow, exception}), 32'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] m;
    logic [15:0] pa[10], pb[10];
    int sent, c, n0, lat;

    // Model pinned to hand-computed values
    m = model(16'h3FC0, 16'h4000, 0); chk("model_3fc0x4000", 32'(m), {13'd0, 3'b000, 16'h4040});
    m = model(16'h7F00, 16'h4000, 0); chk("model_overflow", 32'(m), {13'd0, 3'b100, 16'h7F80});
    m = model(16'h3FC3, 16'h3FC3, 4); chk("model_trunc4", 32'(m), {13'd0, 3'b000, 16'h4010});
    m = model(16'h7F80, 16'h0000, 0); chk("model_inf_x_zero", 32'(m), {13'd0, 3'b001, 16'h7FC0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'({overflow, underflow, exception}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    run_one(16'h3FC0, 16'h4000, 16'h4040, 3'b000, "basic");
`ifdef FPMULT_RNE_ROUND_EN
    run_one(16'h3FC3, 16'h3FC3, 16'h4015, 3'b000, "round");
`else
    run_one(16'h3FC3, 16'h3FC3, 16'h4014, 3'b000, "round");
`endif
    run_one(16'h7F00, 16'h4000, 16'h7F80, 3'b100, "overflow");
    run_one(16'h0080, 16'h3F00, 16'h0000, 3'b010, "underflow");
    run_one(16'h7F80, 16'h0000, 16'h7FC0, 3'b001, "inf_x_zero");
    run_one(16'hFF80, 16'h4000, 16'hFF80, 3'b001, "neg_inf");
    run_one(16'h7FC1, 16'h3F80, 16'h7FC0, 3'b001, "nan");
    run_one(16'h8000, 16'h4000, 16'h8000, 3'b000, "neg_zero");
    run_one(16'hC000, 16'h4000, 16'hC080, 3'b000, "neg_product");

    // Truncated-mantissa instance
    @(posedge clk); #1;
    in_valid_t = 1'b1;
    a_t = 16'h3FC3;
    b_t = 16'h3FC3;
    @(posedge clk); #1;
    in_valid_t = 1'b0;
    lat = 1;
    while (!out_valid_t && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    m = model(16'h3FC3, 16'h3FC3, 4);
    chk("trunc4_latency", 32'(lat), 32'd3);
    chk("trunc4_result", 32'(result_t), 32'h4010);
    chk("trunc4_vs_model", 32'({ov_t, un_t, ex_t, result_t}), 32'(m));

    // Backpressure: 10 pairs, consumer stalls for cycles 4-8
    for (int i = 0; i < 10; i++) begin
      pa[i] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
      pb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
    end
    @(posedge clk); #1;
    saw_low = 1'b0;
    max_infl = 0;
    n0 = n_out;
    sent = 0;
    c = 0;
    while ((n_out - n0) < 10 && c < 200) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        a_operand = pa[sent];
        b_operand = pb[sent];
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(n_out - n0), 32'd10);
    chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);
    chk("bp_max_inflight", 32'(max_infl), 32'd3);

    // Asynchronous reset with two pairs in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_operand = 16'h3FC0;
    b_operand = 16'h4000;
    @(posedge clk); #1;
    a_operand = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_result", 32'(result), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_ghost_result", 32'(out_valid), 32'd0);
    end

    // Randomized streaming with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a_operand = rand_op();
      b_operand = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
